// File: rtl/box_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : box_decoder
//  Description : Raster-stream bounding-box decoder. Tracks the extent and
//                count of lit pixels in each frame, publishes top/left/
//                bottom/right once per frame and flags non-rectangular
//                lit regions and misplaced frame markers.
//  Revision    : 1.0 - initial release
// ============================================================================
module box_decoder #(
    parameter int WIDTH  = 80,
    parameter int HEIGHT = 24,
    parameter int X_BITS = 7,
    parameter int Y_BITS = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     frameStart,
    input  logic                     pixel,
    output logic signed [Y_BITS:0]   top,
    output logic signed [X_BITS:0]   left,
    output logic signed [Y_BITS:0]   bottom,
    output logic signed [X_BITS:0]   right,
    output logic                     boxValid,
    output logic                     boxEmpty,
    output logic                     nonRect,
    output logic                     syncError
);

    localparam int CW = $clog2(WIDTH * HEIGHT + 1);
    localparam int PW = X_BITS + Y_BITS + 2;
    localparam logic [Y_BITS:0] ROW_LAST = (Y_BITS+1)'(HEIGHT - 1);
    localparam logic [X_BITS:0] COL_LAST = (X_BITS+1)'(WIDTH - 1);
    localparam logic [Y_BITS:0] ROW_ONE  = (Y_BITS+1)'(1);
    localparam logic [X_BITS:0] COL_ONE  = (X_BITS+1)'(1);

    typedef enum logic [0:0] {
        WAIT_SYNC = 1'b0,
        SCAN      = 1'b1
    } state_t;

    state_t           state;
    logic [Y_BITS:0]  row_cnt;
    logic [X_BITS:0]  col_cnt;
    logic [Y_BITS:0]  min_row, max_row;
    logic [X_BITS:0]  min_col, max_col;
    logic             any_lit;
    logic [CW-1:0]    lit_count;

    logic             sample;
    logic             last_pix;
    logic [Y_BITS:0]  pos_row;
    logic [X_BITS:0]  pos_col;
    logic             base_any;
    logic [CW-1:0]    base_cnt;
    logic [Y_BITS:0]  nx_min_row, nx_max_row;
    logic [X_BITS:0]  nx_min_col, nx_max_col;
    logic             nx_any;
    logic [CW-1:0]    nx_cnt;
    logic [Y_BITS:0]  box_h;
    logic [X_BITS:0]  box_w;
    logic [PW-1:0]    area;

    // Accumulator next-state: a frameStart restarts the frame at (0,0) with
    // empty accumulators, so the current pixel is folded into a fresh frame.
    always_comb begin
        sample     = frameStart || (state == SCAN);
        pos_row    = frameStart ? '0 : row_cnt;
        pos_col    = frameStart ? '0 : col_cnt;
        last_pix   = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
        base_any   = frameStart ? 1'b0 : any_lit;
        base_cnt   = frameStart ? '0 : lit_count;
        nx_min_row = min_row;
        nx_max_row = max_row;
        nx_min_col = min_col;
        nx_max_col = max_col;
        if (pixel) begin
            if (!base_any) begin
                nx_min_row = pos_row;
                nx_max_row = pos_row;
                nx_min_col = pos_col;
                nx_max_col = pos_col;
            end else begin
                if (pos_row < min_row) nx_min_row = pos_row;
                if (pos_row > max_row) nx_max_row = pos_row;
                if (pos_col < min_col) nx_min_col = pos_col;
                if (pos_col > max_col) nx_max_col = pos_col;
            end
        end
        nx_any = base_any | pixel;
        nx_cnt = base_cnt + CW'(pixel);
        box_h  = nx_max_row - nx_min_row + ROW_ONE;
        box_w  = nx_max_col - nx_min_col + COL_ONE;
        area   = PW'(box_h) * PW'(box_w);
    end

    // Raster scan FSM, per-frame accumulators and registered publish outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= WAIT_SYNC;
            row_cnt   <= '0;
            col_cnt   <= '0;
            min_row   <= '0;
            max_row   <= '0;
            min_col   <= '0;
            max_col   <= '0;
            any_lit   <= 1'b0;
            lit_count <= '0;
            top       <= '0;
            left      <= '0;
            bottom    <= '0;
            right     <= '0;
            boxValid  <= 1'b0;
            boxEmpty  <= 1'b1;
            nonRect   <= 1'b0;
            syncError <= 1'b0;
        end else begin
            boxValid  <= 1'b0;
            syncError <= 1'b0;
            if (sample) begin
                // A marker inside a running scan means the source slipped.
                syncError <= frameStart && (state == SCAN) &&
                             ((row_cnt != '0) || (col_cnt != '0));
                min_row   <= nx_min_row;
                max_row   <= nx_max_row;
                min_col   <= nx_min_col;
                max_col   <= nx_max_col;
                any_lit   <= nx_any;
                lit_count <= nx_cnt;
                if (last_pix) begin
                    state    <= WAIT_SYNC;
                    row_cnt  <= '0;
                    col_cnt  <= '0;
                    boxValid <= 1'b1;
                    if (nx_any) begin
                        top      <= $signed(nx_min_row);
                        left     <= $signed(nx_min_col);
                        bottom   <= $signed(nx_max_row + ROW_ONE);
                        right    <= $signed(nx_max_col + COL_ONE);
                        boxEmpty <= 1'b0;
                        nonRect  <= (PW'(nx_cnt) != area);
                    end else begin
                        boxEmpty <= 1'b1;
                        nonRect  <= 1'b0;
                    end
                end else begin
                    state <= SCAN;
                    if (pos_col == COL_LAST) begin
                        col_cnt <= '0;
                        row_cnt <= pos_row + ROW_ONE;
                    end else begin
                        col_cnt <= pos_col + COL_ONE;
                        row_cnt <= pos_row;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
